// File: rtl/vga_text_renderer.sv
// Text-mode pixel generator: 80x30 cells of 8x16 pixels, internal character buffer,
// external font ROM lookup, sync re-alignment and one blinking cursor cell.
module vga_text_renderer #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [9:0]  pixelx,
  input  logic [9:0]  pixely,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [11:0] wr_addr,
  input  logic [6:0]  wr_data,
  input  logic [11:0] cursor_addr,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int          CELLS   = COLS * ROWS;
  localparam logic [11:0] CELLS_W = 12'(CELLS);
  localparam logic [11:0] COLS_W  = 12'(COLS);
  localparam int          CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  logic [6:0]  char_mem [0:CELLS-1];
  logic [11:0] rd_addr;
  logic [6:0]  rd_data;
  logic        wr_en;

  // stage 1 registers
  logic [6:0]  char1;
  logic [2:0]  x1;
  logic [3:0]  y1;
  logic        vid1, hs1, vs1, cur1;
  // stage 2 registers (font_addr is the stage 2 char/row register)
  logic [2:0]  x2;
  logic        vid2, hs2, vs2, cur2;

  logic             vs_prev;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_on;
  logic             pix;

  assign rd_addr  = {7'd0, pixely[8:4]} * COLS_W + {5'd0, pixelx[9:3]};
  // Rows beyond the grid (blanking lines) read back zero rather than out of range.
  assign rd_data  = (rd_addr < CELLS_W) ? char_mem[rd_addr] : 7'd0;
  // Reads own the tick cycle, so the host may only write between ticks.
  assign wr_ready = ~tick;
  assign wr_en    = wr_valid & ~tick & (wr_addr < CELLS_W);
  assign pix      = font_data[3'd7 - x2] ^ (cur2 & blink_on);

  always_ff @(posedge clk) begin
    if (wr_en) char_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char1     <= 7'd0;
      x1        <= 3'd0;
      y1        <= 4'd0;
      vid1      <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      cur1      <= 1'b0;
      font_addr <= 11'd0;
      x2        <= 3'd0;
      vid2      <= 1'b0;
      hs2       <= 1'b0;
      vs2       <= 1'b0;
      cur2      <= 1'b0;
      rgb       <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (tick) begin
      char1     <= rd_data;
      x1        <= pixelx[2:0];
      y1        <= pixely[3:0];
      vid1      <= video_on;
      hs1       <= hsync_in;
      vs1       <= vsync_in;
      cur1      <= (rd_addr == cursor_addr);
      font_addr <= {char1, y1};
      x2        <= x1;
      vid2      <= vid1;
      hs2       <= hs1;
      vs2       <= vs1;
      cur2      <= cur1;
      rgb       <= vid2 ? (pix ? FG_COLOR : BG_COLOR) : 12'h000;
      hsync_out <= hs2;
      vsync_out <= vs2;
    end
  end

  // A frame starts at each falling edge of vsync_in seen across consecutive ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev   <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (tick) begin
      vs_prev <= vsync_in;
      if (vs_prev && !vsync_in) begin
        if (blink_cnt == CNT_MAX) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer: reset, rendering, write port, cursor blink,
// sync alignment and a two-pass sweep over every cell against a reference model.
module tb_vga_text_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [9:0]  pixelx, pixely;
  logic        video_on, hsync_in, vsync_in;
  logic        wr_valid, wr_ready;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic [11:0] cursor_addr;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int passed = 0;
  int total  = 0;

  vga_text_renderer #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .pixelx(pixelx), .pixely(pixely),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_addr(cursor_addr), .font_addr(font_addr), .font_data(font_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // Font ROM model: char 0 is blank, 'A' row 0 is 8'h18, everything else a fixed hash.
  function automatic logic [7:0] rom(input logic [6:0] ch, input logic [3:0] row);
    logic [7:0] t;
    if (ch == 7'd0) return 8'h00;
    if (ch == 7'h41 && row == 4'd0) return 8'h18;
    t = {1'b0, ch} * 8'd29;
    return t ^ {row, row};
  endfunction

  assign font_data = rom(font_addr[10:4], font_addr[3:0]);

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One tick cycle followed by one idle cycle; rgb then shows the pixel from two calls earlier.
  task automatic px(input int x, input int y, input logic vid, input logic hs, input logic vs);
    pixelx = 10'(x); pixely = 10'(y); video_on = vid; hsync_in = hs; vsync_in = vs;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [6:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic vs_fall();
    px(3, 0, 1'b0, 1'b1, 1'b0);
    px(3, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic cursor_px(input string tag, input logic [11:0] exp);
    px(43, 0, 1'b1, 1'b1, 1'b1);
    px(43, 0, 1'b1, 1'b1, 1'b1);
    px(43, 0, 1'b1, 1'b1, 1'b1);
    check(tag, rgb, exp);
  endtask

  initial begin
    logic [7:0]  hs_pat, vs_pat, g;
    logic [11:0] ea, eb, e;
    logic [6:0]  ch;
    int n, x, y;

    reset = 1'b1; tick = 1'b0; pixelx = '0; pixely = '0; video_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    cursor_addr = 12'hFFF;
    @(posedge clk); #1;
    check("reset_rgb", rgb, 12'h000);
    check("reset_hsync", 12'(hsync_out), 12'h0);
    check("reset_vsync", 12'(vsync_out), 12'h0);
    check("reset_font_addr", 12'(font_addr), 12'h000);
    check("ready_no_tick", 12'(wr_ready), 12'h1);
    tick = 1'b1; #1;
    check("ready_on_tick", 12'(wr_ready), 12'h0);
    tick = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Glyph 8'h18: x=3 lit, x=0 dark.
    wr(12'd0, 7'h41);
    px(3, 0, 1'b1, 1'b1, 1'b1);
    px(0, 0, 1'b1, 1'b1, 1'b1);
    px(0, 0, 1'b1, 1'b1, 1'b1);
    check("glyph_x3", rgb, 12'hFFF);
    px(0, 0, 1'b1, 1'b1, 1'b1);
    check("glyph_x0", rgb, 12'h000);

    // Reset mid-frame clears outputs at once and flushes the pipeline.
    px(3, 0, 1'b1, 1'b1, 1'b1);
    px(3, 0, 1'b1, 1'b1, 1'b1);
    px(3, 0, 1'b1, 1'b1, 1'b1);
    check("pre_reset_rgb", rgb, 12'hFFF);
    check("pre_reset_hsync", 12'(hsync_out), 12'h1);
    reset = 1'b1; #1;
    check("midreset_rgb", rgb, 12'h000);
    check("midreset_hsync", 12'(hsync_out), 12'h0);
    check("midreset_vsync", 12'(vsync_out), 12'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    px(3, 0, 1'b1, 1'b1, 1'b1);
    px(3, 0, 1'b1, 1'b1, 1'b1);
    check("flushed_rgb", rgb, 12'h000);
    px(3, 0, 1'b1, 1'b1, 1'b1);
    check("resumed_rgb", rgb, 12'hFFF);

    // Write requested on a tick cycle waits for the following cycle.
    tick = 1'b1; wr_valid = 1'b1; wr_addr = 12'd1; wr_data = 7'h41; #1;
    check("ready_low_tick", 12'(wr_ready), 12'h0);
    @(posedge clk); #1;
    tick = 1'b0; #1;
    check("ready_high_idle", 12'(wr_ready), 12'h1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    px(11, 0, 1'b1, 1'b1, 1'b1);
    px(11, 0, 1'b1, 1'b1, 1'b1);
    px(11, 0, 1'b1, 1'b1, 1'b1);
    check("deferred_write", rgb, 12'hFFF);

    // Out-of-range write is acknowledged but leaves the last cell alone.
    wr(12'd2399, 7'h41);
    wr_valid = 1'b1; wr_addr = 12'd2400; wr_data = 7'h00; #1;
    check("oor_ack", 12'(wr_ready), 12'h1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    px(635, 464, 1'b1, 1'b1, 1'b1);
    px(635, 464, 1'b1, 1'b1, 1'b1);
    px(635, 464, 1'b1, 1'b1, 1'b1);
    check("cell_2399_kept", rgb, 12'hFFF);

    // Cursor on blank cell 5, two frames per blink phase.
    wr(12'd5, 7'h00);
    cursor_addr = 12'd5;
    cursor_px("cursor_f0", 12'h000);
    vs_fall();
    cursor_px("cursor_f1", 12'h000);
    vs_fall();
    cursor_px("cursor_f2", 12'hFFF);
    vs_fall();
    cursor_px("cursor_f3", 12'hFFF);
    vs_fall();
    cursor_px("cursor_f4", 12'h000);
    cursor_addr = 12'hFFF;

    // Sync outputs trail inputs by the pipeline latency; video_on low blanks a lit pixel.
    hs_pat = 8'b1011_0010;
    vs_pat = 8'b0110_1100;
    for (int i = 0; i < 8; i++) begin
      px(3, 0, 1'b0, hs_pat[i], vs_pat[i]);
      if (i >= 2) begin
        check($sformatf("hsync_d%0d", i), 12'(hsync_out), 12'(hs_pat[i-2]));
        check($sformatf("vsync_d%0d", i), 12'(vsync_out), 12'(vs_pat[i-2]));
        check($sformatf("blank_d%0d", i), rgb, 12'h000);
      end
    end

    // Whole grid against the reference model, two passes with different in-cell offsets.
    for (int a = 0; a < 2400; a++) wr(12'(a), 7'(a));
    n = 0; ea = '0; eb = '0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 32; r++) begin
        for (int c = 0; c < 81; c++) begin
          if (r < 30 && c < 80) begin
            x  = c * 8 + ((c + f * 3) % 8);
            y  = r * 16 + ((r + f * 5) % 16);
            ch = 7'((r * 80 + c) % 128);
            g  = rom(ch, 4'(y % 16));
            e  = g[3'(7 - (x % 8))] ? 12'hFFF : 12'h000;
            px(x, y, 1'b1, 1'b1, 1'b1);
          end else begin
            x = (c < 80) ? c * 8 : 700;
            y = r * 16;
            e = 12'h000;
            px(x, y, 1'b0, 1'b1, 1'b1);
          end
          if (n >= 2) check($sformatf("sweep_f%0d_r%0d_c%0d", f, r, c), rgb, ea);
          ea = eb; eb = e; n++;
          if (r >= 30 && c >= 3) break;
        end
      end
    end
    px(0, 0, 1'b0, 1'b1, 1'b1);
    check("sweep_tail0", rgb, ea);
    px(0, 0, 1'b0, 1'b1, 1'b1);
    check("sweep_tail1", rgb, eb);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
